// File: rtl/conv_output_writer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | conv_output_writer_pkg: shared FSM states, pixel width, saturator |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
package conv_output_writer_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic signed [PIX_W-1:0] sat_pix(input logic signed [31:0] v);
    if (v > 32'sd127) begin
      return 8'sd127;
    end else if (v < -32'sd128) begin
      return -8'sd128;
    end
    return v[PIX_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_out_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | conv_out_ram: DEPTH x 8 buffer, one write port, registered read   |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module conv_out_ram
  import conv_output_writer_pkg::*;
#(
  parameter int DEPTH = 9,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [PIX_W-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [PIX_W-1:0] rdata_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PIX_W-1:0] rdata_q;

  // Storage is never reset so a frame survives a mid-frame reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/conv_output_writer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | conv_output_writer: shifts/saturates raster pixels into a buffer. |
// | Option CONV_OUT_RELU_EN clamps negative shifted values to zero.   |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module conv_output_writer
  import conv_output_writer_pkg::*;
#(
  parameter  int OUT_H = 3,
  parameter  int OUT_W = 3,
  parameter  int SHIFT = 0,
  localparam int DEPTH = OUT_H * OUT_W,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int YW    = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               in_valid_i,
  input  logic signed [31:0] in_pixel_i,
  input  logic               rd_en_i,
  input  logic [AW-1:0]      rd_addr_i,
  output logic [PIX_W-1:0]   rd_data_o,
  output logic               busy_o,
  output logic               frame_done_o,
  output logic [YW-1:0]      out_y_o,
  output logic [XW-1:0]      out_x_o,
  output logic               err_o
);

  state_e             state_q;
  logic               busy_q;
  logic               frame_done_q;
  logic               err_q;
  logic [YW-1:0]      out_y_q;
  logic [XW-1:0]      out_x_q;
  logic               wr_en_q;
  logic [AW-1:0]      wr_addr_q;
  logic [PIX_W-1:0]   wr_data_q;

  logic signed [31:0] shifted_d;
  logic signed [31:0] rect_d;
  logic [PIX_W-1:0]   pix_d;
  logic [AW-1:0]      wr_addr_d;
  logic               last_d;

  assign shifted_d = in_pixel_i >>> SHIFT;
`ifdef CONV_OUT_RELU_EN
  assign rect_d = shifted_d[31] ? 32'sd0 : shifted_d;
`else
  assign rect_d = shifted_d;
`endif
  assign pix_d     = sat_pix(rect_d);
  assign wr_addr_d = AW'(int'(out_y_q) * OUT_W + int'(out_x_q));
  assign last_d    = (out_y_q == YW'(OUT_H - 1)) && (out_x_q == XW'(OUT_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      out_y_q      <= '0;
      out_x_q      <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      // A start always wins, including over a same-cycle pixel.
      if (start_i) begin
        state_q <= ARMED;
        busy_q  <= 1'b1;
        err_q   <= 1'b0;
        out_y_q <= '0;
        out_x_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (in_valid_i) err_q <= 1'b1;
          end
          ARMED: begin
            if (in_valid_i) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= wr_addr_d;
              wr_data_q <= pix_d;
              if (last_d) begin
                state_q      <= DONE;
                busy_q       <= 1'b0;
                frame_done_q <= 1'b1;
                out_y_q      <= '0;
                out_x_q      <= '0;
              end else if (out_x_q == XW'(OUT_W - 1)) begin
                out_x_q <= '0;
                out_y_q <= out_y_q + YW'(1);
              end else begin
                out_x_q <= out_x_q + XW'(1);
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
            if (in_valid_i) err_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  conv_out_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we_i   (wr_en_q),
    .waddr_i(wr_addr_q),
    .wdata_i(wr_data_q),
    .re_i   (rd_en_i),
    .raddr_i(rd_addr_i),
    .rdata_o(rd_data_o)
  );

  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
  assign err_o        = err_q;
  assign out_y_o      = out_y_q;
  assign out_x_o      = out_x_q;

endmodule
`default_nettype wire

// File: doc/conv_output_writer.md
CONV_OUTPUT_WRITER -- requirements
Module: conv_output_writer

Interface
REQ-001 The block SHALL have parameter OUT_H, default 3, output feature-map rows.
REQ-002 The block SHALL have parameter OUT_W, default 3, output feature-map columns.
REQ-003 The block SHALL have parameter SHIFT, default 0, arithmetic right shift applied to each pixel before saturation.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle pulse; arms the block for a new frame.
REQ-007 in_valid  input  1  in_pixel is valid this cycle; pixels arrive in raster order.
REQ-008 in_pixel  input  32  signed convolution result.
REQ-009 rd_en  input  1  buffer read request.
REQ-010 rd_addr  input  clog2(OUT_H*OUT_W)  buffer read address, row-major (y*OUT_W+x).
REQ-011 rd_data  output  8  signed stored pixel, valid the cycle after rd_en.
REQ-012 busy  output  1  high while ARMED.
REQ-013 frame_done  output  1  one-cycle pulse after the final pixel is stored.
REQ-014 out_y, out_x  output  clog2(OUT_H), clog2(OUT_W)  raster coordinates of the next expected pixel.
REQ-015 err  output  1  sticky protocol error flag.

Function
REQ-016 The state machine SHALL have states IDLE, ARMED, DONE.
- IDLE->ARMED on start.
- ARMED->DONE on accepted final pixel.
- DONE->IDLE next cycle; frame_done=1 only in DONE.
REQ-017 On start in any state, the block SHALL clear out_y, out_x and err and enter ARMED; buffer contents SHALL NOT be cleared.
REQ-018 In ARMED, each in_valid SHALL register the processed pixel and coordinates; the buffer write SHALL occur one cycle later (write latency 1).
REQ-019 out_x SHALL increment per accepted pixel and wrap to 0 at OUT_W-1; on that wrap out_y SHALL increment.
REQ-020 Processing SHALL be: arithmetic shift right by SHIFT (floor toward negative infinity), then saturation to [-128,127].
REQ-021 in_valid outside ARMED SHALL set err and SHALL NOT write the buffer or move coordinates.
REQ-022 start and in_valid in the same cycle SHALL restart the frame; that pixel SHALL be discarded without setting err.
REQ-023 rd_data SHALL update only on rd_en; reading the address written in the same cycle SHALL return the old data.
REQ-024 Reads SHALL be permitted in every state.

Reset
REQ-025 On rst, state SHALL be IDLE and busy, frame_done, err, out_y, out_x, rd_data SHALL be 0; any pending write SHALL be dropped.
REQ-026 Reset SHALL NOT clear buffer contents; a reset mid-frame SHALL leave partially written data readable.

Configuration
REQ-027 With macro CONV_OUT_RELU_EN defined, negative shifted values SHALL become 0 before saturation; without it, negative values SHALL be saturated and stored unchanged.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, ARMED, DONE) and the 8-bit pixel-width constant.
REQ-029 The buffer SHALL be the sub-module conv_out_ram: OUT_H*OUT_W x 8, one write port, one registered read port.

Verification
REQ-030 4x4 input 1..16 convolved with kernel [[1,0],[0,-1]], 9 pixels of -32'sd5 after start, RELU off -> frame_done one cycle after the 9th write; all 9 addresses read -5.
REQ-031 Same stimulus with CONV_OUT_RELU_EN -> all 9 addresses read 0.
REQ-032 Pixels 1000, -1000, 127, -129 -> stored 127, -128, 127, -128.
REQ-033 SHIFT=2, pixels 13 and -5 -> stored 3 and -2.
REQ-034 in_valid in IDLE -> err=1, no write, out_x=0. A following start -> err=0.
REQ-035 rst after 4 of 9 pixels -> busy=0, out_y=out_x=0; addresses 0..3 keep their written values. A new start plus 9 pixels -> frame_done.
